// File: rtl/ex_mem_pipe.sv
// EX/MEM pipeline register as a 2-entry skid buffer (head + skid) with registered in_ready.
// Optional branch resolution in the MEM stage is enabled with `define EX_BRANCH_RESOLVE_EN.
module ex_mem_pipe #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned RD_W   = 5
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] ResultE,
   input  logic [3:0]        FlagsE,
   input  logic [DATA_W-1:0] WriteDataE,
   input  logic [RD_W-1:0]   RdE,
   input  logic              RegWriteE,
   input  logic              MemWriteE,
   input  logic              ResultSrcE,
   input  logic              BranchE,
   input  logic [2:0]        Funct3E,
   input  logic              flush,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] ResultM,
   output logic [3:0]        FlagsM,
   output logic [DATA_W-1:0] WriteDataM,
   output logic [RD_W-1:0]   RdM,
   output logic              RegWriteM,
   output logic              MemWriteM,
   output logic              ResultSrcM,
   output logic              PCSrcM
);

   typedef struct packed {
      logic [DATA_W-1:0] result;
      logic [3:0]        flags;
      logic [DATA_W-1:0] wdata;
      logic [RD_W-1:0]   rd;
      logic              regwrite;
      logic              memwrite;
      logic              resultsrc;
`ifdef EX_BRANCH_RESOLVE_EN
      logic              branch;
      logic [2:0]        funct3;
`endif
   } entry_t;

   entry_t in_entry;
   entry_t head_q, head_d;
   entry_t skid_q, skid_d;
   logic   head_valid_q, head_valid_d;
   logic   skid_valid_q, skid_valid_d;
   logic   ready_q;
   logic   accept;
   logic   consume;

   // Gather the execute-stage inputs into one entry
   always_comb begin
      in_entry           = '0;
      in_entry.result    = ResultE;
      in_entry.flags     = FlagsE;
      in_entry.wdata     = WriteDataE;
      in_entry.rd        = RdE;
      in_entry.regwrite  = RegWriteE;
      in_entry.memwrite  = MemWriteE;
      in_entry.resultsrc = ResultSrcE;
`ifdef EX_BRANCH_RESOLVE_EN
      in_entry.branch    = BranchE;
      in_entry.funct3    = Funct3E;
`endif
   end

   assign accept  = in_valid & ready_q;
   assign consume = head_valid_q & out_ready;

   // Next-state: payload only moves on accept or head refill; flush overrides everything
   always_comb begin
      head_d       = head_q;
      skid_d       = skid_q;
      head_valid_d = head_valid_q;
      skid_valid_d = skid_valid_q;
      if (flush) begin
         head_valid_d = 1'b0;
         skid_valid_d = 1'b0;
      end else if (!head_valid_q) begin
         if (accept) begin
            head_d       = in_entry;
            head_valid_d = 1'b1;
         end
      end else if (!skid_valid_q) begin
         case ({accept, consume})
            2'b11: head_d = in_entry;
            2'b10: begin
               skid_d       = in_entry;
               skid_valid_d = 1'b1;
            end
            2'b01: head_valid_d = 1'b0;
            default: ;
         endcase
      end else if (consume) begin
         head_d       = skid_q;
         skid_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         head_q       <= '0;
         skid_q       <= '0;
         head_valid_q <= 1'b0;
         skid_valid_q <= 1'b0;
         ready_q      <= 1'b1;
      end else begin
         head_q       <= head_d;
         skid_q       <= skid_d;
         head_valid_q <= head_valid_d;
         skid_valid_q <= skid_valid_d;
         ready_q      <= ~skid_valid_d;
      end
   end

   assign in_ready   = ready_q;
   assign out_valid  = head_valid_q;
   assign ResultM    = head_q.result;
   assign FlagsM     = head_q.flags;
   assign WriteDataM = head_q.wdata;
   assign RdM        = head_q.rd;
   assign ResultSrcM = head_q.resultsrc;
   assign RegWriteM  = head_valid_q & head_q.regwrite;
   assign MemWriteM  = head_valid_q & head_q.memwrite;

`ifdef EX_BRANCH_RESOLVE_EN
   // Flags are packed {V,C,Z,N}
   function automatic logic branch_cond(input logic [2:0] f3, input logic [3:0] fl);
      logic n, z, c, v;
      {v, c, z, n} = fl;
      case (f3)
         3'b000:  branch_cond = z;
         3'b001:  branch_cond = ~z;
         3'b100:  branch_cond = n ^ v;
         3'b101:  branch_cond = ~(n ^ v);
         3'b110:  branch_cond = ~c;
         3'b111:  branch_cond = c;
         default: branch_cond = 1'b0;
      endcase
   endfunction

   assign PCSrcM = head_valid_q & head_q.branch & branch_cond(head_q.funct3, head_q.flags);
`else
   logic unused_branch;
   assign unused_branch = ^{BranchE, Funct3E};
   assign PCSrcM        = 1'b0;
`endif

endmodule

// File: tb/tb_ex_mem_pipe.sv
// Self-checking bench for ex_mem_pipe: FIFO queue model compared every cycle plus directed literal checks.
module tb_ex_mem_pipe;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid, in_ready;
   logic [31:0] ResultE, WriteDataE;
   logic [3:0]  FlagsE;
   logic [4:0]  RdE;
   logic        RegWriteE, MemWriteE, ResultSrcE, BranchE;
   logic [2:0]  Funct3E;
   logic        flush, out_valid, out_ready;
   logic [31:0] ResultM, WriteDataM;
   logic [3:0]  FlagsM;
   logic [4:0]  RdM;
   logic        RegWriteM, MemWriteM, ResultSrcM, PCSrcM;

   int checks   = 0;
   int failures = 0;

`ifdef EX_BRANCH_RESOLVE_EN
   localparam bit BR_EN = 1'b1;
`else
   localparam bit BR_EN = 1'b0;
`endif

   typedef struct packed {
      logic [31:0] result;
      logic [3:0]  flags;
      logic [31:0] wd;
      logic [4:0]  rd;
      logic        rw, mw, rs, br;
      logic [2:0]  f3;
   } ent_t;

   ent_t q[$];

   ex_mem_pipe dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .ResultE(ResultE), .FlagsE(FlagsE), .WriteDataE(WriteDataE), .RdE(RdE),
      .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .ResultSrcE(ResultSrcE),
      .BranchE(BranchE), .Funct3E(Funct3E),
      .flush(flush),
      .out_valid(out_valid), .out_ready(out_ready),
      .ResultM(ResultM), .FlagsM(FlagsM), .WriteDataM(WriteDataM), .RdM(RdM),
      .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM),
      .PCSrcM(PCSrcM)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h expected=%0h at %0t", name, got, exp, $time);
      end
   endtask

   // All side fields are derived from the result value so each entry is distinguishable
   task automatic drive(input logic v, input logic [31:0] r);
      in_valid   = v;
      ResultE    = r;
      FlagsE     = r[3:0];
      WriteDataE = ~r;
      RdE        = r[4:0] ^ 5'h15;
      BranchE    = r[7];
      Funct3E    = r[6:4];
      RegWriteE  = r[8];
      MemWriteE  = r[9];
      ResultSrcE = r[10];
   endtask

   function automatic ent_t cur_entry();
      ent_t e;
      e.result = ResultE;
      e.flags  = FlagsE;
      e.wd     = WriteDataE;
      e.rd     = RdE;
      e.rw     = RegWriteE;
      e.mw     = MemWriteE;
      e.rs     = ResultSrcE;
      e.br     = BranchE;
      e.f3     = Funct3E;
      return e;
   endfunction

   function automatic logic [127:0] payload(input ent_t e);
      return 128'({e.result, e.flags, e.wd, e.rd, e.rw, e.mw, e.rs});
   endfunction

   // Branch outcome from the flags {V,C,Z,N}
   function automatic logic taken(input ent_t e);
      logic n, z, c, v, cond;
      n = e.flags[0];
      z = e.flags[1];
      c = e.flags[2];
      v = e.flags[3];
      case (e.f3)
         3'd0:    cond = z;
         3'd1:    cond = !z;
         3'd4:    cond = n != v;
         3'd5:    cond = n == v;
         3'd6:    cond = !c;
         3'd7:    cond = c;
         default: cond = 1'b0;
      endcase
      return BR_EN && e.br && cond;
   endfunction

   // Reference FIFO of capacity two
   always @(posedge clk or negedge rst) begin
      bit acc, con;
      if (!rst || flush) begin
         q.delete();
      end else begin
         acc = in_valid && (q.size() < 2);
         con = out_ready && (q.size() > 0);
         if (con) void'(q.pop_front());
         if (acc) q.push_back(cur_entry());
      end
   end

   always @(negedge clk) begin
      check("in_ready", 128'(in_ready), 128'(q.size() < 2));
      check("out_valid", 128'(out_valid), 128'(q.size() > 0));
      if (q.size() > 0) begin
         check("payload", 128'({ResultM, FlagsM, WriteDataM, RdM, RegWriteM, MemWriteM, ResultSrcM}),
               payload(q[0]));
         check("pcsrc", 128'(PCSrcM), 128'(taken(q[0])));
      end else begin
         check("gated_empty", 128'({RegWriteM, MemWriteM, PCSrcM}), 128'(0));
      end
   end

   initial begin
      rst       = 1'b0;
      flush     = 1'b0;
      out_ready = 1'b0;
      drive(1'b0, 32'h0);
      repeat (2) @(negedge clk);
      check("rst_in_ready", 128'(in_ready), 128'(1));
      check("rst_out_valid", 128'(out_valid), 128'(0));
      check("rst_result", 128'(ResultM), 128'(0));
      check("rst_flags", 128'(FlagsM), 128'(0));
      check("rst_wdata", 128'(WriteDataM), 128'(0));
      check("rst_rd", 128'(RdM), 128'(0));
      check("rst_regwrite", 128'(RegWriteM), 128'(0));
      check("rst_memwrite", 128'(MemWriteM), 128'(0));
      check("rst_resultsrc", 128'(ResultSrcM), 128'(0));
      check("rst_pcsrc", 128'(PCSrcM), 128'(0));

      // One-cycle latency, then back-to-back streaming
      rst       = 1'b1;
      out_ready = 1'b1;
      drive(1'b1, 32'h0000_00AA);
      @(negedge clk);
      check("first_valid", 128'(out_valid), 128'(1));
      check("first_data", 128'(ResultM), 128'(32'hAA));
      for (int i = 0; i < 10; i++) begin
         drive(1'b1, 32'h100 + 32'(i));
         @(negedge clk);
         check("b2b_data", 128'(ResultM), 128'(32'h100 + 32'(i)));
         check("b2b_ready", 128'(in_ready), 128'(1));
      end
      drive(1'b0, 32'h0);
      @(negedge clk);
      check("drained", 128'(out_valid), 128'(0));

      // Back-pressure fills the skid register and refuses a third entry
      out_ready = 1'b0;
      drive(1'b1, 32'h11);
      @(negedge clk);
      check("bp_ready1", 128'(in_ready), 128'(1));
      drive(1'b1, 32'h22);
      @(negedge clk);
      check("bp_ready2", 128'(in_ready), 128'(0));
      drive(1'b1, 32'h23);
      @(negedge clk);
      check("bp_refused", 128'(in_ready), 128'(0));
      check("bp_hold", 128'(ResultM), 128'(32'h11));
      drive(1'b0, 32'h0);
      out_ready = 1'b1;
      @(negedge clk);
      check("bp_second", 128'(ResultM), 128'(32'h22));
      check("bp_reopen", 128'(in_ready), 128'(1));
      @(negedge clk);
      check("bp_empty", 128'(out_valid), 128'(0));

      // Flush at occupancy 2 with an input presented
      out_ready = 1'b0;
      drive(1'b1, 32'h44);
      @(negedge clk);
      drive(1'b1, 32'h55);
      @(negedge clk);
      drive(1'b1, 32'h33);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      drive(1'b0, 32'h0);
      check("flush2_valid", 128'(out_valid), 128'(0));
      check("flush2_ready", 128'(in_ready), 128'(1));
      out_ready = 1'b1;
      repeat (3) @(negedge clk);

      // Flush at occupancy 1 discards a simultaneously accepted entry
      out_ready = 1'b0;
      drive(1'b1, 32'h66);
      @(negedge clk);
      drive(1'b1, 32'h77);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      drive(1'b0, 32'h0);
      check("flush1_valid", 128'(out_valid), 128'(0));
      out_ready = 1'b1;
      repeat (2) @(negedge clk);

      // Branch resolution: blt with N=1,V=0 taken; bgeu-style ~C with C=1 not taken
      drive(1'b1, 32'hC1);
      @(negedge clk);
      check("br_lt", 128'(PCSrcM), 128'(BR_EN));
      drive(1'b1, 32'hE4);
      @(negedge clk);
      check("br_nc", 128'(PCSrcM), 128'(0));
      drive(1'b0, 32'h0);
      @(negedge clk);
      check("br_empty", 128'(PCSrcM), 128'(0));

      // Mixed traffic with back-pressure and one flush
      for (int i = 0; i < 60; i++) begin
         drive((i % 3) != 0, 32'hBEEF_0000 ^ (32'(i) * 32'h9E37));
         out_ready = (i % 4) < 2;
         flush     = (i == 23);
         @(negedge clk);
      end
      flush = 1'b0;
      drive(1'b0, 32'h0);
      out_ready = 1'b1;
      repeat (3) @(negedge clk);

      // Asynchronous reset while holding two entries
      out_ready = 1'b0;
      drive(1'b1, 32'h88);
      @(negedge clk);
      drive(1'b1, 32'h99);
      @(negedge clk);
      drive(1'b0, 32'h0);
      check("pre_rst_valid", 128'(out_valid), 128'(1));
      check("pre_rst_ready", 128'(in_ready), 128'(0));
      #3 rst = 1'b0;
      #1;
      check("async_valid", 128'(out_valid), 128'(0));
      check("async_ready", 128'(in_ready), 128'(1));
      check("async_result", 128'(ResultM), 128'(0));
      check("async_regwrite", 128'(RegWriteM), 128'(0));
      @(negedge clk);
      rst       = 1'b1;
      out_ready = 1'b1;
      drive(1'b1, 32'hAB);
      @(negedge clk);
      check("post_rst_valid", 128'(out_valid), 128'(1));
      check("post_rst_data", 128'(ResultM), 128'(32'hAB));
      drive(1'b0, 32'h0);
      @(negedge clk);
      check("post_rst_empty", 128'(out_valid), 128'(0));
      @(negedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/ex_mem_pipe.md
EX_MEM_PIPE -- requirements
Module: ex_mem_pipe

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, giving the width of the result and store data.
REQ-002 The block SHALL have parameter RD_W, default 5, giving the width of the destination register index.
REQ-003 Port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 Port rst  input  1  asynchronous, active-low reset.
REQ-005 Port in_valid  input  1  the execute stage presents a valid entry.
REQ-006 Port in_ready  output  1  the block accepts the entry this cycle.
REQ-007 Port ResultE  input  DATA_W  the ALU result.
REQ-008 Port FlagsE  input  4  the ALU flags, packed {V,C,Z,N}.
REQ-009 Port WriteDataE  input  DATA_W  the store data.
REQ-010 Port RdE  input  RD_W  the destination register index.
REQ-011 Inputs RegWriteE, MemWriteE, ResultSrcE and BranchE SHALL each be 1 bit; Funct3E SHALL be 3 bits.
REQ-012 Port flush  input  1  synchronous discard of all held entries.
REQ-013 Port out_valid  output  1  the head entry is valid.
REQ-014 Port out_ready  input  1  the downstream stage consumes the head entry.
REQ-015 Outputs ResultM, FlagsM, WriteDataM, RdM, RegWriteM, MemWriteM and ResultSrcM SHALL be the head entry, with the same widths as their E-side inputs.
REQ-016 Port PCSrcM  output  1  the branch is taken, resolved from the head entry.

Function
REQ-017 The block SHALL be a 2-entry skid buffer with a head register and a skid register, holding 0 to 2 entries.
REQ-018 in_ready SHALL be registered and equal to NOT skid_valid; it SHALL NOT depend combinationally on out_ready.
REQ-019 An entry SHALL be accepted when in_valid and in_ready are both 1; it SHALL be consumed when out_valid and out_ready are both 1.
REQ-020 Occupancy 0, accept: the entry SHALL load the head register, and out_valid SHALL be 1 on the next cycle (1-cycle latency).
REQ-021 Occupancy 1, accept and consume in the same cycle: the head register SHALL load the new entry, and occupancy SHALL stay 1.
REQ-022 Occupancy 1, accept without consume: the entry SHALL load the skid register, occupancy SHALL become 2, and in_ready SHALL be 0 on the next cycle.
REQ-023 Occupancy 2, consume: the skid register SHALL move to the head, occupancy SHALL become 1, and in_ready SHALL be 1 on the next cycle.
REQ-024 Entries SHALL leave in strict FIFO order and SHALL NOT be dropped or duplicated, except by flush.
REQ-025 While out_valid is 1 and out_ready is 0, all M-side outputs SHALL hold stable.
REQ-026 flush SHALL clear the head and skid valid bits on the next edge, and an input accepted in the same cycle SHALL be discarded; flush wins over every simultaneous event.
REQ-027 Payload registers SHALL load only on accept or shift; their contents SHALL be don't-care while the matching valid bit is 0.
REQ-028 RegWriteM, MemWriteM and PCSrcM SHALL be gated by out_valid, so they read 0 when the block is empty.

Reset
REQ-029 When rst is 0, the block SHALL asynchronously drive both valid bits to 0, in_ready to 1, out_valid to 0, all M-side outputs to 0 and PCSrcM to 0.
REQ-030 Reset asserted mid-transfer SHALL discard all held entries; after reset deasserts, the first edge SHALL be able to accept an entry.

Configuration
REQ-031 When macro EX_BRANCH_RESOLVE_EN is defined, PCSrcM SHALL be out_valid AND BranchM AND cond, where cond is selected by Funct3M.
REQ-032 cond SHALL be: 000 Z, 001 ~Z, 100 N^V, 101 ~(N^V), 110 ~C, 111 C; 010 and 011 SHALL give 0.
REQ-033 When EX_BRANCH_RESOLVE_EN is defined, BranchE and Funct3E SHALL be stored in each entry.
REQ-034 When EX_BRANCH_RESOLVE_EN is not defined, PCSrcM SHALL be tied to 0, and BranchE and Funct3E SHALL be ignored and not stored.

Verification
REQ-035 Reset with in_valid=0 -> in_ready=1, out_valid=0, all M-side outputs 0.
REQ-036 Send ResultE=0x0000_00AA with out_ready=1 held -> ResultM=0xAA one cycle later; 10 back-to-back entries pass through in order at 1 per cycle.
REQ-037 out_ready=0, send 0x11 then 0x22 -> in_ready falls after the second accept, a third entry is refused, then out_ready=1 yields 0x11 followed by 0x22.
REQ-038 Occupancy 2 with flush=1 and in_valid=1 (0x33) -> next cycle out_valid=0 and in_ready=1, and 0x33 never appears.
REQ-039 With EX_BRANCH_RESOLVE_EN: BranchE=1, Funct3E=100, FlagsE=4'b0001 (N=1, V=0) -> PCSrcM=1; Funct3E=110 with C=1 -> PCSrcM=0.
REQ-040 Assert rst while holding 2 entries -> out_valid=0 immediately without a clock edge, and the held entries are lost after rst deasserts.
